// File: rtl/booth_radix4_mul_if.sv
// Handshake and result bundle between the NTT controller and the radix-4 Booth multiplier.
// The multiplier connects through the slave modport, the controller through the master modport.
interface booth_radix4_mul_if #(
    parameter int WIDTH = 16
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;
    logic [2:0]             booth_sel;

    modport master (
        output start, a, b,
        input  busy, done, product, booth_sel
    );

    modport slave (
        input  start, a, b,
        output busy, done, product, booth_sel
    );
endinterface

// File: rtl/booth_radix4_mul.sv
// Sequential signed radix-4 Booth multiplier: two multiplier bits retired per cycle,
// WIDTH/2 accumulate cycles per product, result held until the next completion.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one Booth digit accumulated per cycle
// DONE  | one-cycle completion pulse; start here chains straight into RUN
module booth_radix4_mul #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    booth_radix4_mul_if.slave bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH / 2 - 1);
    localparam logic [PW-1:0]    ONE  = PW'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [PW-1:0]      mcand;
    logic [PW-1:0]      acc;
    logic [PW-1:0]      pp;
    logic [PW-1:0]      acc_sum;
    logic [PW-1:0]      mcand_x2;
    logic [WIDTH:0]     mplier;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         sel;
    logic               busy_q;
    logic               done_q;
    logic [PW-1:0]      product_q;

    assign sel      = mplier[2:0];
    assign mcand_x2 = mcand << 1;
    assign acc_sum  = acc + pp;

    always_comb begin
        pp = '0;
        case (sel)
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand_x2;
            3'b100:         pp = ~mcand_x2 + ONE;
            3'b101, 3'b110: pp = ~mcand + ONE;
            default:        pp = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        mcand  <= {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
                        mplier <= {bus.b, 1'b0};
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 2;
                    mplier <= {{2{mplier[WIDTH]}}, mplier[WIDTH:2]};
                    cnt    <= cnt + CNT_W'(1);
                    // The last digit's sum bypasses acc so done and product line up.
                    if (cnt == LAST) begin
                        product_q <= acc_sum;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.product   = product_q;
    assign bus.booth_sel = (state == RUN) ? sel : 3'b000;
endmodule

// File: tb/tb_booth_radix4_mul.sv
// Self-checking bench for booth_radix4_mul at WIDTH=16: directed test-plan cases
// plus random operands against an integer-multiply reference.
module tb_booth_radix4_mul;
    localparam int W = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    booth_radix4_mul_if #(.WIDTH(W)) bus ();

    booth_radix4_mul #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_product(input logic signed [15:0] av, input logic signed [15:0] bv);
        int p;
        p = int'(av) * int'(bv);
        return p;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.booth_sel, bus.product} !== 37'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b sel=%b product=%h, want all zero",
                     bus.busy, bus.done, bus.booth_sel, bus.product);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.booth_sel, bus.product} !== 37'd0) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%b done=%b sel=%b product=%h, want all zero",
                     bus.busy, bus.done, bus.booth_sel, bus.product);
        end
    endtask

    // One product with full checking: RUN length, Booth digit sequence, done pulse, result, hold.
    task automatic run_mul(input string nm, input logic signed [15:0] av, input logic signed [15:0] bv);
        logic [31:0] exp_p;
        logic [16:0] bx;
        logic [2:0]  exp_sel;
        int          nbusy;
        bit          seen_done;
        exp_p = ref_product(av, bv);
        bx    = {bv, 1'b0};
        @(negedge clk);
        bus.start = 1'b1; bus.a = av; bus.b = bv;
        @(negedge clk);
        bus.start = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom);
        nbusy = 0;
        seen_done = 0;
        for (int cyc = 0; cyc < 20 && !seen_done; cyc++) begin
            if (bus.done) begin
                seen_done = 1;
            end else begin
                if (bus.busy && nbusy < W / 2) begin
                    exp_sel = bx[2*nbusy +: 3];
                    checks++;
                    if (bus.booth_sel !== exp_sel) begin
                        failures++;
                        $display("FAIL %s_sel[%0d]: got %b want %b", nm, nbusy, bus.booth_sel, exp_sel);
                    end
                end
                if (bus.busy) nbusy++;
                @(negedge clk);
            end
        end
        checks++;
        if (!seen_done) begin
            failures++;
            $display("FAIL %s_timeout: done not seen within budget, busy cycles=%0d", nm, nbusy);
        end
        checks++;
        if (nbusy != W / 2) begin
            failures++;
            $display("FAIL %s_busy_len: got %0d cycles want %0d", nm, nbusy, W / 2);
        end
        checks++;
        if (bus.product !== exp_p) begin
            failures++;
            $display("FAIL %s_product: got %h want %h", nm, bus.product, exp_p);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.booth_sel !== 3'b000) begin
            failures++;
            $display("FAIL %s_done_cycle: got busy=%b sel=%b want busy=0 sel=000", nm, bus.busy, bus.booth_sel);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.product !== exp_p) begin
            failures++;
            $display("FAIL %s_after_done: got done=%b product=%h want done=0 product=%h",
                     nm, bus.done, bus.product, exp_p);
        end
    endtask

    task automatic test_directed();
        run_mul("small_pos", 16'sd3, 16'sd5);
        run_mul("neg_a", -16'sd7, 16'sd6);
        run_mul("neg_b", 16'sd6, -16'sd7);
        run_mul("min_min", 16'sh8000, 16'sh8000);
        run_mul("max_min", 16'sh7fff, 16'sh8000);
        run_mul("zero_neg1", 16'sd0, -16'sd1);
    endtask

    task automatic test_random();
        logic signed [15:0] av;
        logic signed [15:0] bv;
        for (int i = 0; i < 40; i++) begin
            av = 16'($urandom);
            bv = 16'($urandom);
            run_mul("rand", av, bv);
        end
    endtask

    task automatic test_start_while_busy();
        int ndone;
        int nbusy;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'd3; bus.b = 16'd5;
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0;
        nbusy = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (bus.busy) nbusy++;
            if (bus.done) begin
                ndone++;
                checks++;
                if (bus.product !== 32'd15) begin
                    failures++;
                    $display("FAIL busy_ign_product: got %h want %h", bus.product, 32'd15);
                end
            end
            bus.start = (cyc == 3);
            bus.a = 16'd100; bus.b = 16'd100;
            @(negedge clk);
        end
        bus.start = 1'b0;
        checks++;
        if (ndone != 1 || nbusy != W / 2) begin
            failures++;
            $display("FAIL busy_ign_count: got done=%0d busy=%0d want done=1 busy=%0d", ndone, nbusy, W / 2);
        end
    endtask

    task automatic test_back_to_back();
        int t_first;
        int t_second;
        int t;
        t_first = -1;
        t_second = -1;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'sd2; bus.b = 16'sd2;
        for (t = 0; t < 40 && t_second < 0; t++) begin
            @(negedge clk);
            if (t_first >= 0 && t == t_first + 1) bus.start = 1'b0;
            if (bus.done) begin
                if (t_first < 0) begin
                    t_first = t;
                    checks++;
                    if (bus.product !== 32'd4) begin
                        failures++;
                        $display("FAIL b2b_first: got %h want %h", bus.product, 32'd4);
                    end
                    bus.a = -16'sd2; bus.b = 16'sd3;
                end else begin
                    t_second = t;
                    checks++;
                    if (bus.product !== 32'hffff_fffa) begin
                        failures++;
                        $display("FAIL b2b_second: got %h want %h", bus.product, 32'hffff_fffa);
                    end
                end
            end else if (t_first >= 0 && bus.busy) begin
                checks++;
                if (bus.product !== 32'd4) begin
                    failures++;
                    $display("FAIL b2b_hold: got %h want %h", bus.product, 32'd4);
                end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (t_first < 0 || t_second < 0 || t_second - t_first != W / 2 + 1) begin
            failures++;
            $display("FAIL b2b_spacing: got first=%0d second=%0d want spacing %0d", t_first, t_second, W / 2 + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'sd1234; bus.b = -16'sd77;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_pre: got busy=%b want 1", bus.busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.booth_sel, bus.product} !== 37'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b sel=%b product=%h, want all zero",
                     bus.busy, bus.done, bus.booth_sel, bus.product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_idle: got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        run_mul("post_reset", 16'sd9, 16'sd9);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_start_while_busy();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/booth_radix4_mul.md
# booth_radix4_mul

Sequential signed radix-4 Booth multiplier: the encoder side of the Booth datapath. It scans the multiplier two bits per cycle, forms the 3-bit Booth digit (`sel`), and accumulates the matching partial product into a 2·WIDTH-bit accumulator. The block serves as the coefficient multiplier ahead of the modular-reduction stage in the NTT butterfly, where small area matters more than throughput. A start/busy/done handshake lets the NTT controller issue one product at a time.

## Interface
- `WIDTH`, default 16: signed operand width; must be even and ≥ 4. The product is 2·WIDTH bits.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a multiply; sampled on the rising edge.
- `a`  in  WIDTH: multiplicand, two's complement; sampled when `start` is accepted.
- `b`  in  WIDTH: multiplier, two's complement; sampled when `start` is accepted.
- `busy`  out  1: high while the multiply is running (state RUN).
- `done`  out  1: single-cycle pulse; `product` is valid from this cycle on.
- `product`  out  2·WIDTH: signed result; held until the next completion.
- `booth_sel`  out  3: Booth digit being applied this cycle; 0 when not in RUN.

## Operation
- **States:** IDLE, RUN, DONE. Reset puts the block in IDLE.
- **Start acceptance:**
  - `start` is accepted in IDLE or DONE and ignored in RUN.
  - On acceptance:
    - `mcand` ← `a` sign-extended to 2·WIDTH.
    - `mplier` ← {`b`, 1'b0} (WIDTH+1 bits).
    - `acc` ← 0; `cnt` ← 0; state → RUN.
- **Booth digit:** `booth_sel` = `mplier[2:0]` while in RUN.
- **Partial product `pp` (2·WIDTH bits, mod 2^(2·WIDTH)):**
  - `sel` 000 or 111 → 0.
  - `sel` 001 or 010 → +`mcand`.
  - `sel` 011 → +(`mcand`<<1).
  - `sel` 100 → −(`mcand`<<1), formed as ~x+1.
  - `sel` 101 or 110 → −`mcand`.
- **Each RUN cycle:**
  - `acc` ← `acc` + `pp`.
  - `mcand` ← `mcand` << 2.
  - `mplier` ← `mplier` >> 2, arithmetic, so sign bits are replicated.
  - `cnt` ← `cnt` + 1.
- **Leaving RUN:** when `cnt` = WIDTH/2−1, the final accumulation is written directly into `product`, state → DONE, and `done` is asserted.
- **DONE:** lasts exactly one cycle, then → IDLE, unless `start` is high, in which case → RUN with new operands.
- **Arithmetic:** all arithmetic wraps modulo 2^(2·WIDTH). No overflow is possible for in-range operands, including (−2^(W−1))².
- **Result register:** `product` is written only on completion. It is not disturbed by a new start and is cleared only by reset.
- **Reset mid-operation:** aborts immediately.
  - State → IDLE.
  - `busy`, `done`, `booth_sel`, `product` → 0.
  - The partial result is discarded.

## Timing
- **Reset values:** `busy` = 0, `done` = 0, `booth_sel` = 0, `product` = 0.
- **Latency:** `start` accepted at edge k → `busy` high from k to k+WIDTH/2, i.e. WIDTH/2 cycles.
  - `done` pulses high in the cycle after edge k+WIDTH/2, with `product` valid then.
  - Example, WIDTH = 16: 8 RUN cycles; `done` at edge k+8.
- **Throughput:** back-to-back starts, with `start` held high in the DONE cycle, give one product every WIDTH/2+1 cycles.
- **Start while busy:** has no effect on operands, counter, or the result.
- **Combinational paths:** `booth_sel` is combinational from registered state only. There is no input-to-output combinational path.

## Test plan
- **Small positive:** WIDTH=16, a=3, b=5, start 1 cycle → busy for 8 cycles, done pulse, product=0x0000000F, booth_sel sequence 010,010,000…
- **Mixed sign:** a=−7, b=6 → product=0xFFFFFFD6 (−42); a=6, b=−7 → same product.
- **Extremes:**
  - a=−32768, b=−32768 → 0x40000000.
  - a=32767, b=−32768 → 0xC0008000.
  - a=0, b=−1 → 0x00000000.
- **Start ignored while busy:** start a=3, b=5; pulse start with a=100, b=100 during RUN cycle 3 → single done, product=15, busy never extended.
- **Back-to-back:** hold start high through DONE with a=2, b=2, then a=−2, b=3 → done pulses 9 cycles apart, products 4 then 0xFFFFFFFA.
- **Reset mid-operation:** assert rst_n=0 in RUN cycle 4 → all outputs 0 immediately. After release, start a=9, b=9 → product=81 with normal latency.
